// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions used by the memory-stage controller and its helpers.
package cpu_types_pkg;

    // Memory-stage access sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    // Default watchdog limit, in ACCESS cycles without a cache response
    localparam int MEM_TIMEOUT_DEFAULT = 255;

    // Width of the watchdog counter
    localparam int MEM_WD_W = 8;

endpackage

// File: rtl/mem_watchdog.sv
// Access watchdog: 8-bit counter with synchronous clear, count enable and a
// terminal-count flag that fires in the cycle whose increment would reach TIMEOUT.
module mem_watchdog
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [MEM_WD_W-1:0] TC_VAL = MEM_WD_W'(TIMEOUT - 1);

    logic [MEM_WD_W-1:0] r_count;

    // Count waited cycles; clear has priority so a fresh access always starts at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = i_en && (r_count == TC_VAL);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues the data-cache request for the EX/MEM
// instruction, stalls upstream while it is outstanding, captures load data for
// MEM/WB, latches halt, and aborts accesses the cache never answers.
module mem_stage_ctrl
    import cpu_types_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              dREN_in,
    input  logic              dWEN_in,
    input  logic [WORD_W-1:0] addr_in,
    input  logic [WORD_W-1:0] store_in,
    input  logic              halt_in,
    input  logic              down_ready,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [WORD_W-1:0] load_data,
    output logic              halted,
    output logic              timeout_err
);

    mem_state_t        r_state;
    mem_state_t        w_state_next;
    logic              r_is_store;
    logic [WORD_W-1:0] r_load_data;
    logic              r_halted;
    logic              r_timeout_err;

    logic              w_pending;
    logic              w_ren;
    logic              w_wen;
    logic              w_stall;
    logic [WORD_W-1:0] w_addr;
    logic [WORD_W-1:0] w_store;
    logic              w_cap_load;
    logic              w_abort;
    logic              w_set_halt;
    logic              w_wd_clear;
    logic              w_wd_en;
    logic              w_wd_tc;

    // A flushed slot or a halted core never generates cache traffic
    assign w_pending  = in_valid && (dREN_in || dWEN_in) && !r_halted;

    // Watchdog restarts whenever IDLE hands a missed request over to ACCESS
    assign w_wd_clear = (r_state == IDLE) && w_pending && !dhit;
    assign w_wd_en    = (r_state == ACCESS) && !dhit;

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_wd_clear),
        .i_en    (w_wd_en),
        .o_tc    (w_wd_tc)
    );

    // Next-state and output decode; a hit always beats the watchdog
    always_comb begin
        w_state_next = r_state;
        w_ren        = 1'b0;
        w_wen        = 1'b0;
        w_stall      = 1'b0;
        w_addr       = '0;
        w_store      = '0;
        w_cap_load   = 1'b0;
        w_abort      = 1'b0;
        w_set_halt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pending) begin
                    // Store wins when both strobes are requested
                    w_wen   = dWEN_in;
                    w_ren   = !dWEN_in;
                    w_stall = 1'b1;
                    if (dhit) begin
                        w_cap_load   = !dWEN_in;
                        w_state_next = DONE;
                    end else begin
                        w_state_next = ACCESS;
                    end
                end else if (in_valid && halt_in) begin
                    w_set_halt = 1'b1;
                end
            end
            ACCESS: begin
                w_wen   = r_is_store;
                w_ren   = !r_is_store;
                w_stall = 1'b1;
                w_addr  = addr_in;
                w_store = store_in;
                if (dhit) begin
                    w_cap_load   = !r_is_store;
                    w_state_next = DONE;
                end else if (w_wd_tc) begin
                    w_abort      = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                // Strobes stay low so the completed access is not re-issued
                w_stall = !down_ready;
                if (down_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, access type, captured data and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_is_store    <= 1'b0;
            r_load_data   <= '0;
            r_halted      <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_wd_clear) begin
                r_is_store <= dWEN_in;
            end
            if (w_cap_load) begin
                r_load_data <= dmemload;
            end else if (w_abort) begin
                r_load_data <= '0;
            end
            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end
            if (w_set_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Reset kills the strobes and the stall combinationally, even mid-access
    assign dmemREN     = w_ren && !rst;
    assign dmemWEN     = w_wen && !rst;
    assign mem_stall   = w_stall && !rst;
    assign dmemaddr    = w_addr;
    assign dmemstore   = w_store;
    assign load_data   = r_load_data;
    assign halted      = r_halted;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl. Expectations come from a
// transaction-level model: a request holds its strobe and the stall for
// min(hit cycle, 1+TIMEOUT) cycles, followed by bp+1 completion cycles.
module tb_mem_stage_ctrl;

    localparam int W  = 32;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         dREN_in = 1'b0;
    logic         dWEN_in = 1'b0;
    logic         halt_in = 1'b0;
    logic         down_ready = 1'b0;
    logic         dhit = 1'b0;
    logic [W-1:0] addr_in = '0;
    logic [W-1:0] store_in = '0;
    logic [W-1:0] dmemload = '0;
    logic         dmemREN;
    logic         dmemWEN;
    logic         mem_stall;
    logic         halted;
    logic         timeout_err;
    logic [W-1:0] dmemaddr;
    logic [W-1:0] dmemstore;
    logic [W-1:0] load_data;

    int           total = 0;
    int           bad = 0;
    logic [W-1:0] exp_load = '0;
    logic         exp_halt = 1'b0;
    logic         exp_err = 1'b0;

    mem_stage_ctrl #(
        .WORD_W  (W),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .dREN_in     (dREN_in),
        .dWEN_in     (dWEN_in),
        .addr_in     (addr_in),
        .store_in    (store_in),
        .halt_in     (halt_in),
        .down_ready  (down_ready),
        .dhit        (dhit),
        .dmemload    (dmemload),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .dmemaddr    (dmemaddr),
        .dmemstore   (dmemstore),
        .mem_stall   (mem_stall),
        .load_data   (load_data),
        .halted      (halted),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic w, input logic h,
                         input logic [W-1:0] a, input logic [W-1:0] s,
                         input logic dr, input logic hit, input logic [W-1:0] ld);
        in_valid   = v;
        dREN_in    = r;
        dWEN_in    = w;
        halt_in    = h;
        addr_in    = a;
        store_in   = s;
        down_ready = dr;
        dhit       = hit;
        dmemload   = ld;
    endtask

    // Sample on the falling edge, then advance to just after the next rising edge
    task automatic chk_cycle(input string tag, input logic er, input logic ew, input logic es,
                             input logic ca, input logic [W-1:0] ea, input logic [W-1:0] estore);
        @(negedge clk);
        check({tag, ".ren"}, {31'd0, dmemREN}, {31'd0, er});
        check({tag, ".wen"}, {31'd0, dmemWEN}, {31'd0, ew});
        check({tag, ".stall"}, {31'd0, mem_stall}, {31'd0, es});
        if (ca) begin
            check({tag, ".addr"}, dmemaddr, ea);
            check({tag, ".wdata"}, dmemstore, estore);
        end
        check({tag, ".load"}, load_data, exp_load);
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, exp_halt});
        check({tag, ".toerr"}, {31'd0, timeout_err}, {31'd0, exp_err});
        @(posedge clk);
        #1;
    endtask

    // One memory instruction: hit on request cycle k (0 = never), bp cycles of backpressure
    task automatic mem_txn(input string tag, input bit is_store, input bit rd_too,
                           input logic [W-1:0] a, input logic [W-1:0] d,
                           input int k, input int bp, input logic [W-1:0] word);
        bit timed_out;
        int n;
        timed_out = (k == 0) || (k > 1 + TO);
        n = timed_out ? 1 + TO : k;
        for (int c = 1; c <= n; c++) begin
            drive(1'b1, (!is_store) || rd_too, is_store, 1'b0, a, d, 1'($urandom),
                  c == k, (c == k) ? word : $urandom);
            chk_cycle($sformatf("%s.req%0d", tag, c), !is_store, is_store, 1'b1,
                      c > 1, a, d);
        end
        if (timed_out) begin
            exp_load = '0;
            exp_err  = 1'b1;
        end else if (!is_store) begin
            exp_load = word;
        end
        for (int j = 0; j <= bp; j++) begin
            drive(1'b1, (!is_store) || rd_too, is_store, 1'b0, a, d, j == bp,
                  1'($urandom), $urandom);
            chk_cycle($sformatf("%s.done%0d", tag, j), 1'b0, 1'b0, j != bp, 1'b1, '0, '0);
        end
    endtask

    task automatic random_txn(input int id, input int kmax, input bit allow_never);
        int sel;
        int k;
        sel = $urandom_range(0, 9);
        k   = $urandom_range(allow_never ? 0 : 1, kmax);
        if (sel <= 1) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom);
            chk_cycle($sformatf("rnd%0d.alu", id), 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        end else if (sel == 2) begin
            drive(1'b0, 1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom),
                  1'($urandom), $urandom);
            chk_cycle($sformatf("rnd%0d.bubble", id), 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        end else begin
            mem_txn($sformatf("rnd%0d", id), sel >= 7, 1'($urandom), $urandom, $urandom,
                    k, $urandom_range(0, 2), $urandom);
        end
    endtask

    initial begin
        // Reset with a request presented: strobes and stall must stay low
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h1);
        @(posedge clk);
        #1;
        chk_cycle("rst0", 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        chk_cycle("rst1", 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        chk_cycle("post_rst", 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

        // Directed cases
        mem_txn("ld_zero_wait", 1'b0, 1'b0, 32'h100, 32'h0, 1, 0, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h5, 32'h6, 1'b1, 1'b0, '0);
        chk_cycle("alu_pass", 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        mem_txn("st_miss3", 1'b1, 1'b0, 32'h200, 32'h12345678, 3, 0, 32'hFFFF0000);
        mem_txn("st_both", 1'b1, 1'b1, 32'h204, 32'hA5A5A5A5, 2, 0, 32'h0BADF00D);
        mem_txn("ld_bp2", 1'b0, 1'b0, 32'h300, 32'h0, 1, 2, 32'h0C0FFEE0);
        mem_txn("ld_hit_at_limit", 1'b0, 1'b0, 32'h304, 32'h0, 1 + TO, 0, 32'h13579BDF);

        // Random traffic that always hits before the watchdog limit
        for (int i = 0; i < 40; i++) begin
            random_txn(i, 1 + TO, 1'b0);
        end

        // Cache that never answers
        mem_txn("ld_timeout", 1'b0, 1'b0, 32'h400, 32'h0, 0, 0, 32'h0);
        mem_txn("ld_after_to", 1'b0, 1'b0, 32'h404, 32'h0, 2, 1, 32'h2468ACE0);

        // Random traffic including late or missing hits
        for (int i = 40; i < 55; i++) begin
            random_txn(i, 2 + 2 * TO, 1'b1);
        end

        // Reset during the second access cycle: no capture, outputs back to reset values
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 1'b1, 1'b0, 32'h0);
        chk_cycle("rma.c1", 1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 1'b1, 1'b1, 32'hCAFEF00D);
        @(negedge clk);
        check("rma.rst.ren", {31'd0, dmemREN}, 32'd0);
        check("rma.rst.wen", {31'd0, dmemWEN}, 32'd0);
        check("rma.rst.stall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_load = '0;
        exp_err  = 1'b0;
        exp_halt = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        chk_cycle("rma.after", 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        mem_txn("ld_after_rma", 1'b0, 1'b0, 32'h600, 32'h0, 2, 0, 32'h600DCAFE);

        // Halt, then requests must be ignored until reset
        drive(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 1'b1, 1'b0, '0);
        chk_cycle("halt", 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        exp_halt = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 1'b1, 1'b1, 32'h77777777);
        chk_cycle("halted.ld", 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h704, 32'h88888888, 1'b0, 1'b0, '0);
        chk_cycle("halted.st", 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_halt = 1'b0;
        exp_load = '0;
        chk_cycle("halt_cleared", 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        mem_txn("ld_after_halt", 1'b0, 1'b0, 32'h800, 32'h0, 1, 0, 32'h89ABCDEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
